// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one unified memory between the CPU and a DMA/loader port,
// with a programmable number of access cycles per transfer and a one-cycle ready pulse.
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ready,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic          grant_dma
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            lastDma_q, lastDma_d;
    logic            ownerDma_q, ownerDma_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            anyReq;
    logic            pickDma;

    // On a tie the port that was not served last wins, so neither requester starves.
    always_comb begin
        anyReq  = cpu_req | dma_req;
        pickDma = dma_req;
        if (cpu_req && dma_req) begin
            pickDma = ~lastDma_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lastDma_q  <= 1'b1;
            ownerDma_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lastDma_q  <= lastDma_d;
            ownerDma_q <= ownerDma_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lastDma_d  = lastDma_q;
        ownerDma_d = ownerDma_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d    = ACCESS;
                    cnt_d      = '0;
                    ownerDma_d = pickDma;
                    we_d       = pickDma ? dma_we    : cpu_we;
                    addr_d     = pickDma ? dma_addr  : cpu_addr;
                    wdata_d    = pickDma ? dma_wdata : cpu_wdata;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                // Memory read data is only guaranteed valid in the final access cycle.
                if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    lastDma_d = ownerDma_q;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode registered state, so reset clears them without waiting for a clock.
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign busy      = (state_q != IDLE);
    assign grant_dma = ownerDma_q;
    assign cpu_ready = (state_q == DONE) & ~ownerDma_q;
    assign dma_ready = (state_q == DONE) &  ownerDma_q;
    assign cpu_rdata = rdata_q;
    assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grant order and
// returned data, a monitor pops predictions whenever a ready pulse appears.
module tb_mem_arbiter;

    localparam int W       = 3;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [31:0] dma_rdata;
    logic        dma_ready;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, grant_dma;

    mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_dma(grant_dma)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // Simple synchronous-write, combinational-read memory behind the arbiter.
    logic [31:0] memArr [0:63];
    initial for (int i = 0; i < 64; i++) memArr[i] = initWord(i);
    always @(posedge clk) if (mem_en && mem_we) memArr[mem_addr[7:2]] <= mem_wdata;
    assign mem_rdata = memArr[mem_addr[7:2]];

    typedef struct {
        bit          isDma;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        bit          isDma;
        logic [31:0] rdata;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] shadow [0:63];
    bit          modelLastDma;
    logic [31:0] modelRdata;
    int          checks = 0;
    int          passed = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic failNow(input string name);
        checks++;
        $display("[TB] FAIL %s: event did not occur as required", name);
    endtask

    // Reference model: a served transfer either updates memory or returns its word;
    // the shared read register keeps its last read value across writes.
    task automatic modelReset();
        modelLastDma = 1'b1;
        modelRdata   = '0;
    endtask

    task automatic modelExec(input txn_t t);
        if (t.we) shadow[t.addr[7:2]] = t.wdata;
        else      modelRdata = shadow[t.addr[7:2]];
        modelLastDma = t.isDma;
        expQ.push_back('{isDma: t.isDma, rdata: modelRdata});
    endtask

    logic prevCpuRdy = 1'b0;
    logic prevDmaRdy = 1'b0;
    exp_t monExp;

    always @(negedge clk) begin
        if (reset && (cpu_ready || dma_ready)) begin
            checkBit("ready_exclusive", cpu_ready & dma_ready, 1'b0);
            checkBit("ready_width", (cpu_ready & prevCpuRdy) | (dma_ready & prevDmaRdy), 1'b0);
            if (expQ.size() == 0) begin
                failNow("unexpected_ready");
            end else begin
                monExp = expQ.pop_front();
                checkBit("ready_port", dma_ready, monExp.isDma);
                checkOutput("cpu_rdata", cpu_rdata, monExp.rdata);
                checkOutput("dma_rdata", dma_rdata, monExp.rdata);
            end
        end
        prevCpuRdy = cpu_ready;
        prevDmaRdy = dma_ready;
    end

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpuDrive(input txn_t t, output int cyc, output int weCnt);
        cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata; cpu_req = 1'b1;
        cyc = 0; weCnt = 0;
        while (cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            if (mem_we) weCnt++;
            if (cpu_ready) break;
        end
        cpu_req = 1'b0;
        if (!cpu_ready) failNow("cpu_timeout");
    endtask

    task automatic dmaDrive(input txn_t t, output int cyc);
        dma_we = t.we; dma_addr = t.addr; dma_wdata = t.wdata; dma_req = 1'b1;
        cyc = 0;
        while (cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            if (dma_ready) break;
        end
        dma_req = 1'b0;
        if (!dma_ready) failNow("dma_timeout");
    endtask

    function automatic txn_t mkTxn(bit isDma, bit we, logic [31:0] addr, logic [31:0] wdata);
        txn_t t;
        t.isDma = isDma; t.we = we; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    // mode 0: CPU alone, 1: DMA alone, 2: both raised together
    task automatic applyStimulus(input int mode, input txn_t c, input txn_t d);
        int c1, w1, c2;
        if (mode == 0) begin
            modelExec(c);
            cpuDrive(c, c1, w1);
        end else if (mode == 1) begin
            modelExec(d);
            dmaDrive(d, c2);
        end else begin
            if (modelLastDma) begin modelExec(c); modelExec(d); end
            else              begin modelExec(d); modelExec(c); end
            fork
                cpuDrive(c, c1, w1);
                dmaDrive(d, c2);
            join
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int   cyc, weCnt, n, readies;
        logic sawBusy;
        logic [31:0] held;
        txn_t cT, dT;

        for (int i = 0; i < 64; i++) shadow[i] = initWord(i);
        modelReset();

        // Reset held with a pending CPU request: everything stays quiet.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        repeat (3) @(negedge clk);
        checkBit("rst_mem_en", mem_en, 1'b0);
        checkBit("rst_mem_we", mem_we, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_grant_dma", grant_dma, 1'b0);
        checkBit("rst_cpu_ready", cpu_ready, 1'b0);
        checkBit("rst_dma_ready", dma_ready, 1'b0);
        checkOutput("rst_rdata", cpu_rdata, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        modelExec(mkTxn(1'b0, 1'b0, 32'h0, 32'h0));
        reset = 1'b1;
        cpuDrive(mkTxn(1'b0, 1'b0, 32'h0, 32'h0), cyc, weCnt);
        checkOutput("rst_release_latency", 32'(cyc), 32'(W + 1));

        // CPU write then read back.
        idleCycles(1);
        cT = mkTxn(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        modelExec(cT);
        cpuDrive(cT, cyc, weCnt);
        checkOutput("wr_latency", 32'(cyc), 32'(W + 1));
        checkOutput("wr_we_cycles", 32'(weCnt), 32'(W));
        idleCycles(1);
        cT = mkTxn(1'b0, 1'b0, 32'h40, 32'h0);
        modelExec(cT);
        cpuDrive(cT, cyc, weCnt);
        checkOutput("rd_latency", 32'(cyc), 32'(W + 1));
        checkOutput("rd_back", cpu_rdata, 32'hDEAD_BEEF);

        // Both ports held for four transfers.
        idleCycles(1);
        cT = mkTxn(1'b0, 1'b0, 32'h10, 32'h0);
        dT = mkTxn(1'b1, 1'b0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (modelLastDma) modelExec(cT);
            else              modelExec(dT);
        end
        cpu_we = 1'b0; cpu_addr = cT.addr; dma_we = 1'b0; dma_addr = dT.addr;
        cpu_req = 1'b1; dma_req = 1'b1;
        n = 0; readies = 0;
        while (readies < 4 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
            if (cpu_ready || dma_ready) readies++;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        checkOutput("contention_cycles", 32'(n), 32'(4 * (W + 2) - 1));

        // DMA drops its request in the middle access cycle.
        idleCycles(1);
        dT = mkTxn(1'b1, 1'b0, 32'h24, 32'h0);
        modelExec(dT);
        dma_we = 1'b0; dma_addr = dT.addr; dma_req = 1'b1;
        idleCycles(2);
        dma_req = 1'b0;
        n = 2;
        while (n < TIMEOUT) begin
            @(negedge clk);
            n++;
            if (dma_ready) break;
        end
        checkOutput("dma_drop_latency", 32'(n), 32'(W + 1));
        sawBusy = 1'b0;
        repeat (W + 3) begin @(negedge clk); sawBusy |= busy; end
        checkBit("dma_drop_no_regrant", sawBusy, 1'b0);

        // Reset during the second access cycle of a write aborts it immediately.
        idleCycles(1);
        cpu_we = 1'b1; cpu_addr = 32'hF0; cpu_wdata = 32'h1234_5678; cpu_req = 1'b1;
        idleCycles(2);
        checkBit("abort_pre_we", mem_we, 1'b1);
        #1 reset = 1'b0; cpu_req = 1'b0;
        #1;
        checkBit("abort_mem_en", mem_en, 1'b0);
        checkBit("abort_mem_we", mem_we, 1'b0);
        checkBit("abort_busy", busy, 1'b0);
        checkOutput("abort_rdata", cpu_rdata, 32'h0);
        modelReset();
        idleCycles(2);
        reset = 1'b1;
        sawBusy = 1'b0;
        repeat (W + 3) begin @(negedge clk); sawBusy |= busy; end
        checkBit("abort_idle_after", sawBusy, 1'b0);

        // CPU read with request held through DONE repeats after one idle cycle.
        cT = mkTxn(1'b0, 1'b0, 32'h08, 32'h0);
        modelExec(cT);
        held = modelRdata;
        modelExec(cT);
        cpu_we = 1'b0; cpu_addr = cT.addr; cpu_req = 1'b1;
        n = 0;
        while (n < TIMEOUT) begin @(negedge clk); n++; if (cpu_ready) break; end
        checkOutput("held_first_latency", 32'(n), 32'(W + 1));
        @(negedge clk);
        checkOutput("held_rdata_between", cpu_rdata, held);
        n = 1;
        while (n < TIMEOUT) begin @(negedge clk); n++; if (cpu_ready) break; end
        cpu_req = 1'b0;
        checkOutput("held_repeat_gap", 32'(n), 32'(W + 2));

        // Randomized mix of solo and contending transfers.
        for (int r = 0; r < 40; r++) begin
            cT = mkTxn(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)) << 2, $urandom);
            dT = mkTxn(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)) << 2, $urandom);
            applyStimulus(int'($urandom_range(0, 2)), cT, dT);
            idleCycles(int'($urandom_range(0, 2)));
        end

        idleCycles(W + 4);
        checkOutput("queue_drained", 32'(expQ.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU port (instruction fetch and load/store, address already selected by the i_or_d mux) and a DMA/loader port used for program load and debug access. It adds a configurable wait-state counter so slower memories can sit behind the core, and returns a one-cycle ready pulse that the control unit uses to hold its current state. One access is in flight at a time; simultaneous requests are resolved round-robin.

## Interface
- AW, 32, address width
- DW, 32, data width
- WAIT_CYCLES, 1, memory access cycles per transfer; legal range 1..15
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- cpu_req  in  1  CPU access request; held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  read data, valid while cpu_ready=1, held until next completion
- cpu_ready  out  1  one-cycle completion pulse for CPU
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  same as CPU equivalents
- dma_rdata  out  DW  same as cpu_rdata
- dma_ready  out  1  one-cycle completion pulse for DMA
- mem_en  out  1  memory enable, high for every ACCESS cycle
- mem_we  out  1  memory write enable, high for every ACCESS cycle of a write
- mem_addr  out  AW  latched address of granted request
- mem_wdata  out  DW  latched write data of granted request
- mem_rdata  in  DW  memory read data, valid in last ACCESS cycle
- busy  out  1  1 in ACCESS or DONE
- grant_dma  out  1  1 while current/last transfer belongs to DMA

## Operation
- States: IDLE, ACCESS, DONE. Encoding is implementation choice.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the port not granted last (last_grant register; reset value DMA, so CPU wins first tie). On grant: latch we, addr, wdata, owner; clear wait counter; go ACCESS.
- ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values. Counter increments each cycle; on counter == WAIT_CYCLES-1 capture mem_rdata into shared rdata register (reads only; writes leave rdata unchanged), update last_grant, go DONE.
- DONE: owner's ready=1 for exactly this cycle; other port's ready=0; go IDLE unconditionally.
- cpu_rdata and dma_rdata both driven from the shared rdata register.
- Requests are sampled only in IDLE; req changes in ACCESS/DONE are ignored. A request dropped mid-transfer still completes and still pulses ready.
- A req still high in the IDLE cycle following DONE is a new request (requester must drop req in the ready cycle to avoid a repeat).
- Inputs addr/we/wdata need only be stable in the IDLE cycle of the grant.

## Timing
- Reset (reset=0, async): state=IDLE, counter=0, last_grant=DMA, all outputs 0, rdata=0, latched addr/wdata=0. Any in-flight access is aborted immediately; mem_en/mem_we drop without waiting for clk.
- Latency: req sampled at edge E0 in IDLE -> ACCESS for WAIT_CYCLES cycles -> ready high in cycle after edge E0+WAIT_CYCLES, i.e. ready visible WAIT_CYCLES+1 cycles after the sampling edge.
- Throughput: one transfer per WAIT_CYCLES+2 cycles under continuous requests (one IDLE bubble).
- Continuous contention alternates CPU, DMA, CPU, ...; neither port starves.
- ready, busy, grant_dma, mem_* are decoded from registered state only (no combinational path from req to any output).

## Test plan
- Reset: hold reset=0 with cpu_req=1 -> all outputs 0; release -> cpu grant, cpu_ready pulses 2 cycles later for WAIT_CYCLES=1.
- CPU write then read, WAIT_CYCLES=3: write 0xDEADBEEF to 0x40 -> mem_we high exactly 3 cycles, cpu_ready one cycle after; read 0x40 -> cpu_rdata=0xDEADBEEF with cpu_ready, dma_ready stays 0.
- Simultaneous cpu_req and dma_req held high for 4 transfers -> grant order CPU, DMA, CPU, DMA; each ready one cycle wide; 4*(WAIT_CYCLES+2) cycles total.
- DMA drops dma_req in middle ACCESS cycle -> transfer completes, dma_ready still pulses, no further grant.
- Reset asserted in second ACCESS cycle of a write (WAIT_CYCLES=3) -> mem_en/mem_we fall before next clk edge, no ready pulse, state IDLE after release.
- Read with cpu_req held through DONE -> second identical transfer starts after one IDLE cycle; cpu_rdata holds first value until second completion.
